// File: rtl/tft_bus_arbiter.sv
// tft_bus_arbiter: arbitrates command and pixel streams onto an 8080-style TFT
// write bus, generating a programmable-width active-low write strobe.
`default_nettype none

module tft_bus_arbiter #(
  parameter int WR_LOW_CYCLES  = 1,
  parameter int WR_HIGH_CYCLES = 1,
  parameter int CMD_BURST_MAX  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic        cmd_rs,
  input  logic [15:0] cmd_data,
  output logic        cmd_ready,
  input  logic        pix_valid,
  input  logic [15:0] pix_data,
  output logic        pix_ready,
  input  logic        bus_hold,
  output logic        screenRD,
  output logic        screenWR,
  output logic        screenRS,
  output logic [15:0] screenData,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_LOW  = 2'd1,
    WR_HIGH = 2'd2
  } state_t;

  localparam logic [3:0] LOW_LAST  = 4'(WR_LOW_CYCLES - 1);
  localparam logic [3:0] HIGH_LAST = 4'(WR_HIGH_CYCLES - 1);
  localparam logic [7:0] BURST_MAX = 8'(CMD_BURST_MAX);

  state_t      state_q;
  logic [3:0]  phase_q;
  logic [7:0]  burst_q;
  logic        wr_q;
  logic        rs_q;
  logic [15:0] data_q;

  logic        grant_opp;
  logic        pix_forced;
  logic        grant;
  logic [7:0]  burst_inc;

  // A new word may start from IDLE or seamlessly on the last WR_HIGH cycle.
  assign grant_opp  = !bus_hold &&
                      ((state_q == IDLE) ||
                       ((state_q == WR_HIGH) && (phase_q == HIGH_LAST)));
  assign pix_forced = pix_valid && (burst_q == BURST_MAX);
  assign cmd_ready  = grant_opp && cmd_valid && !pix_forced;
  assign pix_ready  = grant_opp && pix_valid && (!cmd_valid || pix_forced);
  assign grant      = cmd_ready || pix_ready;
  assign burst_inc  = (burst_q == BURST_MAX) ? burst_q : burst_q + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= 4'd0;
      burst_q <= 8'd0;
      wr_q    <= 1'b1;
      rs_q    <= 1'b1;
      data_q  <= 16'h0000;
    end else if (grant) begin
      state_q <= WR_LOW;
      phase_q <= 4'd0;
      wr_q    <= 1'b0;
      rs_q    <= pix_ready ? 1'b1 : cmd_rs;
      data_q  <= pix_ready ? pix_data : cmd_data;
      burst_q <= pix_ready ? 8'd0 : burst_inc;
    end else begin
      case (state_q)
        WR_LOW: begin
          if (phase_q == LOW_LAST) begin
            state_q <= WR_HIGH;
            phase_q <= 4'd0;
            wr_q    <= 1'b1;
          end else begin
            phase_q <= phase_q + 4'd1;
          end
        end
        WR_HIGH: begin
          if (phase_q == HIGH_LAST) begin
            state_q <= IDLE;
            phase_q <= 4'd0;
          end else begin
            phase_q <= phase_q + 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          phase_q <= 4'd0;
        end
      endcase
    end
  end

  assign screenRD   = 1'b1;
  assign screenWR   = wr_q;
  assign screenRS   = rs_q;
  assign screenData = data_q;
  assign busy       = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_tft_bus_arbiter.sv
// tb_tft_bus_arbiter: directed self-checking bench; dut1 uses default timing,
// dut2 uses a 3-low/2-high strobe. Both share the same stimulus.
`default_nettype none

module tb_tft_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_rs;
  logic [15:0] cmd_data;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        bus_hold;

  logic        cr1, pr1, rd1, wr1, rs1, busy1;
  logic [15:0] data1;
  logic        cr2, pr2, rd2, wr2, rs2, busy2;
  logic [15:0] data2;

  int checks = 0;
  int errors = 0;

  tft_bus_arbiter dut1 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_rs(cmd_rs), .cmd_data(cmd_data), .cmd_ready(cr1),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pr1),
    .bus_hold(bus_hold),
    .screenRD(rd1), .screenWR(wr1), .screenRS(rs1), .screenData(data1), .busy(busy1)
  );

  tft_bus_arbiter #(.WR_LOW_CYCLES(3), .WR_HIGH_CYCLES(2), .CMD_BURST_MAX(4)) dut2 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_rs(cmd_rs), .cmd_data(cmd_data), .cmd_ready(cr2),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pr2),
    .bus_hold(bus_hold),
    .screenRD(rd2), .screenWR(wr2), .screenRS(rs2), .screenData(data2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (wr1 !== 1'b1) begin errors++; $display("FAIL rst_wr got %b exp 1", wr1); end
    checks++; if (rs1 !== 1'b1) begin errors++; $display("FAIL rst_rs got %b exp 1", rs1); end
    checks++; if (data1 !== 16'h0000) begin errors++; $display("FAIL rst_data got %h exp 0000", data1); end
    checks++; if (cr1 !== 1'b0 || pr1 !== 1'b0) begin errors++; $display("FAIL rst_ready got %b%b exp 00", cr1, pr1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy1); end
    checks++; if (rd1 !== 1'b1) begin errors++; $display("FAIL rst_rd got %b exp 1", rd1); end
    checks++; if (wr2 !== 1'b1) begin errors++; $display("FAIL rst_wr2 got %b exp 1", wr2); end
    rst = 1'b0;
  endtask

  task automatic test_single_cmd();
    cmd_valid = 1'b1; cmd_rs = 1'b0; cmd_data = 16'h0011;
    #1;
    checks++; if (cr1 !== 1'b1 || pr1 !== 1'b0) begin errors++; $display("FAIL cmd_ready got %b%b exp 10", cr1, pr1); end
    @(negedge clk); cmd_valid = 1'b0; #1;
    checks++; if (wr1 !== 1'b0) begin errors++; $display("FAIL cmd_wr_low got %b exp 0", wr1); end
    checks++; if (rs1 !== 1'b0) begin errors++; $display("FAIL cmd_rs got %b exp 0", rs1); end
    checks++; if (data1 !== 16'h0011) begin errors++; $display("FAIL cmd_data got %h exp 0011", data1); end
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL cmd_busy got %b exp 1", busy1); end
    @(negedge clk); #1;
    checks++; if (wr1 !== 1'b1 || busy1 !== 1'b1) begin errors++; $display("FAIL cmd_wr_high wr/busy got %b%b exp 11", wr1, busy1); end
    @(negedge clk); #1;
    checks++; if (busy1 !== 1'b0 || wr1 !== 1'b1) begin errors++; $display("FAIL cmd_idle busy/wr got %b%b exp 01", busy1, wr1); end
    checks++; if (data1 !== 16'h0011) begin errors++; $display("FAIL cmd_hold_data got %h exp 0011", data1); end
  endtask

  task automatic test_pixel_stream();
    pix_valid = 1'b1; pix_data = 16'h1000;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (pr1 !== 1'b1 || cr1 !== 1'b0) begin errors++; $display("FAIL pix_ready[%0d] got %b%b exp 01", i, cr1, pr1); end
      if (i > 0) begin
        checks++; if (wr1 !== 1'b1) begin errors++; $display("FAIL pix_wr_high[%0d] got %b exp 1", i, wr1); end
      end
      @(negedge clk);
      pix_data = 16'h1000 + 16'(i + 1);
      #1;
      checks++; if (wr1 !== 1'b0 || rs1 !== 1'b1) begin errors++; $display("FAIL pix_strobe[%0d] wr/rs got %b%b exp 01", i, wr1, rs1); end
      checks++; if (data1 !== 16'h1000 + 16'(i)) begin errors++; $display("FAIL pix_data[%0d] got %h exp %h", i, data1, 16'h1000 + 16'(i)); end
      checks++; if (pr1 !== 1'b0) begin errors++; $display("FAIL pix_ready_low[%0d] got %b exp 0", i, pr1); end
      @(negedge clk);
    end
    pix_valid = 1'b0;
    @(negedge clk); #1;
    checks++; if (busy1 !== 1'b0 || wr1 !== 1'b1 || data1 !== 16'h1003) begin
      errors++; $display("FAIL pix_idle busy/wr/data got %b %b %h exp 0 1 1003", busy1, wr1, data1);
    end
  endtask

  // Expects the burst counter to start at zero: grants go C,C,C,C,P,...
  task automatic test_burst(input int n);
    cmd_valid = 1'b1; cmd_rs = 1'b0; cmd_data = 16'h00C0;
    pix_valid = 1'b1; pix_data = 16'hF800;
    for (int i = 0; i < n; i++) begin
      logic exp_p;
      exp_p = ((i % 5) == 4);
      #1;
      checks++; if (cr1 !== !exp_p || pr1 !== exp_p) begin
        errors++; $display("FAIL burst_grant[%0d] cmd/pix got %b%b exp %b%b", i, cr1, pr1, !exp_p, exp_p);
      end
      @(negedge clk); #1;
      checks++; if (rs1 !== exp_p) begin errors++; $display("FAIL burst_rs[%0d] got %b exp %b", i, rs1, exp_p); end
      @(negedge clk);
    end
    cmd_valid = 1'b0; pix_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_bus_hold();
    cmd_valid = 1'b1; cmd_rs = 1'b0; cmd_data = 16'h0022;
    #1;
    checks++; if (cr1 !== 1'b1) begin errors++; $display("FAIL hold_first_ready got %b exp 1", cr1); end
    @(negedge clk); bus_hold = 1'b1; #1;
    checks++; if (wr1 !== 1'b0) begin errors++; $display("FAIL hold_wr_low got %b exp 0", wr1); end
    @(negedge clk); #1;
    checks++; if (wr1 !== 1'b1 || busy1 !== 1'b1 || cr1 !== 1'b0) begin
      errors++; $display("FAIL hold_wr_high wr/busy/ready got %b%b%b exp 110", wr1, busy1, cr1);
    end
    @(negedge clk); #1;
    checks++; if (busy1 !== 1'b0 || cr1 !== 1'b0) begin errors++; $display("FAIL hold_idle busy/ready got %b%b exp 00", busy1, cr1); end
    @(negedge clk); #1;
    checks++; if (cr1 !== 1'b0) begin errors++; $display("FAIL hold_blocked got %b exp 0", cr1); end
    bus_hold = 1'b0; #1;
    checks++; if (cr1 !== 1'b1) begin errors++; $display("FAIL hold_release_ready got %b exp 1", cr1); end
    @(negedge clk); cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wide_strobe();
    repeat (2) @(negedge clk);
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 16'hA5A5;
    #1;
    checks++; if (cr2 !== 1'b1) begin errors++; $display("FAIL wide_ready0 got %b exp 1", cr2); end
    @(negedge clk); cmd_data = 16'h5A5A;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (wr2 !== (c >= 3) || data2 !== 16'hA5A5 || rs2 !== 1'b1 || busy2 !== 1'b1) begin
        errors++; $display("FAIL wide_cycle[%0d] wr/rs/busy/data got %b%b%b %h exp %b11 a5a5", c, wr2, rs2, busy2, data2, (c >= 3));
      end
      checks++; if (cr2 !== (c == 4)) begin errors++; $display("FAIL wide_ready[%0d] got %b exp %b", c, cr2, (c == 4)); end
      if (c < 4) @(negedge clk);
    end
    @(negedge clk); cmd_valid = 1'b0; #1;
    checks++; if (wr2 !== 1'b0 || data2 !== 16'h5A5A) begin errors++; $display("FAIL wide_b2b wr/data got %b %h exp 0 5a5a", wr2, data2); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_rst_mid();
    cmd_valid = 1'b1; cmd_rs = 1'b0; cmd_data = 16'h0033;
    #1;
    checks++; if (cr1 !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b exp 1", cr1); end
    @(negedge clk); cmd_valid = 1'b0; #1;
    checks++; if (wr1 !== 1'b0) begin errors++; $display("FAIL rmid_wr_low got %b exp 0", wr1); end
    rst = 1'b1; #1;
    checks++; if (wr1 !== 1'b1 || busy1 !== 1'b0 || data1 !== 16'h0000 || rs1 !== 1'b1) begin
      errors++; $display("FAIL rmid_async wr/busy/rs/data got %b%b%b %h exp 101 0000", wr1, busy1, rs1, data1);
    end
    @(negedge clk); rst = 1'b0;
    test_burst(5);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_rs = 1'b0; cmd_data = 16'h0000;
    pix_valid = 1'b0; pix_data = 16'h0000; bus_hold = 1'b0;
    test_reset();
    test_single_cmd();
    test_pixel_stream();
    test_burst(10);
    test_bus_hold();
    test_wide_strobe();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
